// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Circular TX byte FIFO that drains into the UART core through the
//            tx_data / data_write_en / tx_ready handshake.
// Options  : UART_TXFIFO_IRQ_EN adds irq_level input and registered irq output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [7:0]            wdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  data_write_en
`ifdef UART_TXFIFO_IRQ_EN
  ,
  input  logic [DEPTH_LOG2:0]   irq_level,
  output logic                  irq
`endif
);

  localparam int unsigned           c_DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_FULL  = c_DEPTH[DEPTH_LOG2:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [7:0]              mem_q [c_DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr_q;
  logic [DEPTH_LOG2-1:0]   rptr_q;
  logic [DEPTH_LOG2:0]     count_q;
  logic [DEPTH_LOG2:0]     count_d;
  logic                    overflow_q;
  logic [7:0]              tx_data_q;
  logic                    w_pop;
  logic                    w_push_ok;

  assign w_pop     = (state_q == S_LOAD);
  assign w_push_ok = push && (!full || w_pop);

  assign full          = (count_q == c_FULL);
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign tx_data       = tx_data_q;
  // Strobe follows tx_ready live so a core that drops ready after LOAD never sees a load.
  assign data_write_en = (state_q == S_STROBE) && tx_ready;

  always_comb begin
    count_d = count_q;
    if (w_push_ok && !w_pop) begin
      count_d = count_q + (DEPTH_LOG2 + 1)'(1);
    end else if (!w_push_ok && w_pop) begin
      count_d = count_q - (DEPTH_LOG2 + 1)'(1);
    end
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (flush) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (w_push_ok) begin
        wptr_q <= wptr_q + DEPTH_LOG2'(1);
      end
      if (ovf_clr) begin
        overflow_q <= 1'b0;
      end else if (push && !w_push_ok) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (!empty && tx_ready) state_q <= S_LOAD;
        end
        S_LOAD: begin
          tx_data_q <= mem_q[rptr_q];
          rptr_q    <= rptr_q + DEPTH_LOG2'(1);
          state_q   <= S_STROBE;
        end
        S_STROBE: begin
          if (tx_ready) state_q <= S_HOLD;
        end
        S_HOLD: begin
          // The core drops ready once it has taken the byte; only then re-arm.
          if (!tx_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TXFIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= (count_d <= irq_level);
    end
  end

  assign irq = irq_q;
`endif

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit buffer that sits directly upstream of the UART core. Accepts bytes from the CPU register interface into a circular FIFO, then drains them one at a time into the core through its `tx_data` / `data_write_en` / `tx_ready` handshake. This lets software queue bursts without polling `tx_ready` per byte, and reports fill level and overflow.

## Interface

- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `flush` input, 1 bit: synchronous FIFO clear; resets pointers, count and FSM.
- `push` input, 1 bit: write strobe from the CPU side.
- `wdata` input, 8 bits: byte to enqueue.
- `full` output, 1 bit: asserted when `count == 2^DEPTH_LOG2`.
- `empty` output, 1 bit: asserted when `count == 0`.
- `count` output, DEPTH_LOG2+1 bits: number of stored bytes.
- `overflow` output, 1 bit: sticky flag, set when a push is dropped.
- `ovf_clr` input, 1 bit: clears `overflow`.
- `tx_ready` input, 1 bit: from the core; the core is idle and can accept a byte.
- `tx_data` output, 8 bits: to the core; registered byte, stable until the next load.
- `data_write_en` output, 1 bit: to the core; one-cycle load strobe.
- `irq` output, 1 bit: present only with `UART_TXFIFO_IRQ_EN`.
- `irq_level` input, DEPTH_LOG2+1 bits: present only with `UART_TXFIFO_IRQ_EN`.

## Operation

**Storage**
- 2^DEPTH_LOG2 x 8 register array.
- `wptr` and `rptr` are DEPTH_LOG2 bits wide and wrap modulo depth.
- `count` is tracked separately.

**Push**
- Accepted when `push && (!full || pop_this_cycle)`.
- On accept: `mem[wptr] <= wdata`, `wptr++`.
- Push while full with no pop in the same cycle: byte dropped, `overflow <= 1`, pointers unchanged.

**Count**
- `count` is +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.

**Drain FSM (2-bit)**
- IDLE: if `!empty && tx_ready`, go to LOAD.
- LOAD (the pop cycle): `tx_data <= mem[rptr]`, `rptr++`, go to STROBE.
- STROBE: `data_write_en = tx_ready` (combinational from state). If `tx_ready`, go to HOLD; otherwise stay in STROBE with the byte retained. This covers the core being disabled or CTS dropping between IDLE and STROBE.
- HOLD: wait for `tx_ready == 0` (the core has accepted the byte), then go to IDLE.
- HOLD and IDLE's `tx_ready` check together prevent double-issue. `tx_data` is held from LOAD until the next LOAD, covering the core's load cycle after the strobe.

**Overflow and flush**
- `overflow`: `ovf_clr` has priority over a simultaneous overflow event, i.e. the flag clears.
- `flush`: sets pointers, `count` and `overflow` to 0 and the FSM to IDLE. `tx_data` is retained. A byte already strobed into the core is not recalled. `flush` overrides a `push` in the same cycle.

## Timing

- Reset values:
  - `count`=0, `empty`=1, `full`=0, `overflow`=0
  - `tx_data`=8'h00, `data_write_en`=0
  - FSM=IDLE, `wptr`=`rptr`=0
  - `irq`=1 (count 0 <= `irq_level`)
- Latency, FIFO previously empty, core ready:
  - `push` at cycle t.
  - `empty` drops at t+1.
  - LOAD at t+2.
  - `data_write_en` high at t+3.
- Back-to-back bytes: the next LOAD occurs 1 cycle after the core raises `tx_ready` again.
- Full and empty are mutually exclusive for DEPTH_LOG2 >= 1.
- Reset asserted mid-drain: all state clears immediately (async). `data_write_en` deasserts without waiting for a clock.

## Configuration

- `UART_TXFIFO_IRQ_EN` defined:
  - Adds `irq_level` and registered `irq`.
  - `irq <= (count_next <= irq_level)`, level-sensitive, updated every cycle.
- `UART_TXFIFO_IRQ_EN` undefined:
  - `irq_level` and `irq` ports and their logic are absent.
  - All other behaviour is identical.

## Test plan

- **Single byte:** reset; hold `tx_ready`=1; push 8'hA5.
  - `data_write_en` pulses exactly once, 3 cycles after the push, with `tx_data`=8'hA5.
  - `count` returns to 0.
- **Ordered burst:** `tx_ready`=0; push 16 bytes 8'h00..8'h0F.
  - `full`=1, `count`=16.
  - 17th push sets `overflow`=1 and `count` stays 16.
  - Core model then drains 8'h00..8'h0F in order.
- **Wrap and simultaneous events:** with `count`=16, push 8'h55 in the LOAD cycle. Accepted, `count` stays 16, `overflow` stays 0, pointers wrap. 8'h55 is emitted last.
- **Ready drops:** `tx_ready` drops between LOAD and STROBE.
  - No strobe while low; byte held.
  - Single strobe when `tx_ready` returns.
  - No duplicate.
- **Flush and reset:** `flush` with 5 queued bytes gives `count`=0, `empty`=1, and no further strobes. Async `rst` mid-STROBE drops `data_write_en` within the same cycle.
- **IRQ (`UART_TXFIFO_IRQ_EN` defined):** `irq_level`=2.
  - `irq`=1 at `count` 0..2.
  - Pushing to `count`=3 gives `irq`=0.
  - Draining to 2 gives `irq`=1.
